// File: rtl/eg_step_gen.sv
// eg_step_gen: per-operator ADSR envelope generator producing the raw 10-bit
// attenuation (0 = loudest, 0x3FF = silent) for the downstream EG limiter.
// All state advances only on clk edges with clk_en=1 (one EG tick).
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   clk_en        EG tick enable
//   keyon         key level; rising/falling edges detected internally
//   ar/d1r/d2r    attack / first decay / second decay rates (5 bit)
//   rr, sl        release rate and sustain level (4 bit)
//   kc_rate       key-scale rate offset
//   eg_pure       registered envelope attenuation
//   eg_state      registered phase: 0 attack, 1 decay, 2 sustain, 3 release
//   eg_rate       effective rate of the current phase (combinational, debug)
module eg_step_gen #(
   parameter int unsigned CNT_W = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       clk_en,
   input  logic       keyon,
   input  logic [4:0] ar,
   input  logic [4:0] d1r,
   input  logic [4:0] d2r,
   input  logic [3:0] rr,
   input  logic [3:0] sl,
   input  logic [4:0] kc_rate,
   output logic [9:0] eg_pure,
   output logic [1:0] eg_state,
   output logic [5:0] eg_rate
);

   typedef enum logic [1:0] {
      StAttack  = 2'd0,
      StDecay   = 2'd1,
      StSustain = 2'd2,
      StRelease = 2'd3
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               keyon_prev;

   logic [6:0]         base_cur;
   logic [5:0]         ar_rate;
   logic [3:0]         shift;
   logic [CNT_W-1:0]   mask;
   logic               step_due;
   logic [3:0]         inc;
   logic [13:0]        prod;
   logic [9:0]         dec;
   logic [9:0]         atk_next;
   logic [10:0]        sum;
   logic [9:0]         up_next;
   logic [9:0]         sl_lvl;

   // A zero base rate freezes the envelope regardless of key scaling.
   function automatic logic [5:0] eff_rate(input logic [6:0] base, input logic [4:0] kc);
      logic [6:0] total;
      total = base + {2'b00, kc};
      if (base == 7'd0) begin
         return 6'd0;
      end
      return (total > 7'd63) ? 6'd63 : total[5:0];
   endfunction

   assign eg_state = state;

   always_comb begin
      base_cur = 7'd0;
      unique case (state)
         StAttack:  base_cur = {1'b0, ar, 1'b0};
         StDecay:   base_cur = {1'b0, d1r, 1'b0};
         StSustain: base_cur = {1'b0, d2r, 1'b0};
         StRelease: base_cur = {1'b0, rr, 2'b10};
         default:   base_cur = 7'd0;
      endcase
      eg_rate = eff_rate(base_cur, kc_rate);
      ar_rate = eff_rate({1'b0, ar, 1'b0}, kc_rate);

      // Slow rates step once every 2^shift ticks; fast rates step every tick.
      shift    = (eg_rate < 6'd44) ? (4'd11 - eg_rate[5:2]) : 4'd0;
      mask     = (CNT_W'(1) << shift) - CNT_W'(1);
      step_due = ((cnt & mask) == '0);

      if (eg_rate == 6'd0)      inc = 4'd0;
      else if (eg_rate < 6'd48) inc = 4'd1;
      else if (eg_rate < 6'd52) inc = 4'd2;
      else if (eg_rate < 6'd56) inc = 4'd4;
      else                      inc = 4'd8;

      // Exponential attack: step proportional to the remaining attenuation.
      prod     = {4'b0000, eg_pure} * {10'd0, inc};
      dec      = (prod[13:4] == 10'd0) ? 10'd1 : prod[13:4];
      atk_next = (eg_pure > dec) ? (eg_pure - dec) : 10'd0;

      sum      = {1'b0, eg_pure} + {7'd0, inc};
      up_next  = sum[10] ? 10'h3FF : sum[9:0];

      sl_lvl   = (sl == 4'd15) ? 10'h3E0 : {1'b0, sl, 5'b00000};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         eg_pure    <= 10'h3FF;
         state      <= StRelease;
         cnt        <= '0;
         keyon_prev <= 1'b0;
      end else if (clk_en) begin
         keyon_prev <= keyon;
         cnt        <= cnt + CNT_W'(1);
         if (keyon && !keyon_prev) begin
            if (ar_rate >= 6'd62) begin
               eg_pure <= 10'd0;
               state   <= StDecay;
            end else begin
               state   <= StAttack;
            end
         end else if (!keyon && keyon_prev) begin
            state <= StRelease;
         end else if (state == StAttack && eg_pure == 10'd0) begin
            state <= StDecay;
         end else if (state == StDecay && eg_pure >= sl_lvl) begin
            state <= StSustain;
         end else if (step_due && inc != 4'd0) begin
            if (state == StAttack) eg_pure <= atk_next;
            else                   eg_pure <= up_next;
         end
      end
   end

endmodule

// File: tb/tb_eg_step_gen.sv
// tb_eg_step_gen: directed self-checking bench for eg_step_gen. Inputs change
// 1 ns after each rising edge; outputs are sampled at that point.
module tb_eg_step_gen;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       clk_en = 1'b1;
   logic       keyon = 1'b0;
   logic [4:0] ar = '0;
   logic [4:0] d1r = '0;
   logic [4:0] d2r = '0;
   logic [3:0] rr = '0;
   logic [3:0] sl = '0;
   logic [4:0] kc_rate = '0;
   logic [9:0] eg_pure;
   logic [1:0] eg_state;
   logic [5:0] eg_rate;

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   eg_step_gen #(.CNT_W(15)) dut (
      .clk      (clk),
      .rst      (rst),
      .clk_en   (clk_en),
      .keyon    (keyon),
      .ar       (ar),
      .d1r      (d1r),
      .d2r      (d2r),
      .rr       (rr),
      .sl       (sl),
      .kc_rate  (kc_rate),
      .eg_pure  (eg_pure),
      .eg_state (eg_state),
      .eg_rate  (eg_rate)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
      n_cmp++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      keyon = 1'b0;
      rst   = 1'b1;
      @(posedge clk);
      #1;
      rst   = 1'b0;
   endtask

   initial begin
      int guard;

      // Idle after reset: silent release.
      do_reset();
      check("rst_pure", eg_pure, 10'h3FF);
      check("rst_state", eg_state, 3);
      for (int i = 0; i < 10; i++) begin
         tick(1);
         check("idle_pure", eg_pure, 10'h3FF);
         check("idle_state", eg_state, 3);
      end

      // Instant attack at R=62.
      ar = 5'd31;
      keyon = 1'b1;
      tick(1);
      check("inst_pure", eg_pure, 10'h000);
      check("inst_state", eg_state, 1);

      // Slow attack R=40: step on even cnt only.
      do_reset();
      ar = 5'd20; d1r = 5'd0; sl = 4'd0;
      keyon = 1'b1;
      tick(1);
      check("atk_t1_state", eg_state, 0);
      check("atk_t1_pure", eg_pure, 10'h3FF);
      check("atk_rate", eg_rate, 40);
      tick(1);
      check("atk_t2_pure", eg_pure, 10'h3FF);
      tick(1);
      check("atk_t3_pure", eg_pure, 10'h3C0);
      tick(2);
      check("atk_t5_pure", eg_pure, 10'h384);
      guard = 0;
      while (eg_pure != 10'd0 && guard < 1000) begin
         tick(1);
         guard++;
      end
      check("atk_reach0", eg_pure, 0);
      check("atk_at0_state", eg_state, 0);
      tick(1);
      check("atk_exit_state", eg_state, 1);
      check("atk_exit_pure", eg_pure, 0);

      // Decay R=62 toward sl=1 (0x20), then hold in sustain with d2r=0.
      do_reset();
      ar = 5'd31; d1r = 5'd31; d2r = 5'd0; sl = 4'd1; rr = 4'd0; kc_rate = 5'd0;
      keyon = 1'b1;
      tick(1);
      check("dec_start_pure", eg_pure, 0);
      check("dec_start_state", eg_state, 1);
      for (int i = 1; i <= 4; i++) begin
         tick(1);
         check("dec_pure", eg_pure, i * 8);
         check("dec_state", eg_state, 1);
      end
      tick(1);
      check("sus_state", eg_state, 2);
      check("sus_pure", eg_pure, 32);
      tick(3);
      check("sus_hold_pure", eg_pure, 32);
      check("sus_rate0", eg_rate, 0);
      d2r = 5'd30; kc_rate = 5'd5;
      #1;
      check("rate_clamp", eg_rate, 63);
      d2r = 5'd0; kc_rate = 5'd0;
      keyon = 1'b0;
      tick(1);
      check("rel_state", eg_state, 3);
      check("rel_pure", eg_pure, 32);
      check("rel_rate", eg_rate, 2);

      // Asynchronous reset between edges.
      #2;
      rst = 1'b1;
      #1;
      check("arst_pure", eg_pure, 10'h3FF);
      check("arst_state", eg_state, 3);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Key-off mid-attack at 0x200, release R=62 to saturation.
      ar = 5'd31; d1r = 5'd31; sl = 4'd15; rr = 4'd0;
      keyon = 1'b1;
      tick(1);
      check("e_start_pure", eg_pure, 0);
      tick(64);
      check("e_dec_pure", eg_pure, 10'h200);
      check("e_dec_state", eg_state, 1);
      keyon = 1'b0;
      tick(1);
      check("e_rel_state", eg_state, 3);
      ar = 5'd20;
      keyon = 1'b1;
      tick(1);
      check("e_retrig_state", eg_state, 0);
      check("e_retrig_pure", eg_pure, 10'h200);
      keyon = 1'b0; rr = 4'd15;
      tick(1);
      check("koff_state", eg_state, 3);
      check("koff_pure", eg_pure, 10'h200);
      check("koff_rate", eg_rate, 62);
      tick(1);
      check("rel_step1", eg_pure, 10'h208);
      tick(62);
      check("rel_3f8", eg_pure, 10'h3F8);
      tick(1);
      check("rel_sat", eg_pure, 10'h3FF);
      tick(1);
      check("rel_sat_hold", eg_pure, 10'h3FF);
      check("rel_sat_state", eg_state, 3);

      // clk_en low: keyon pulse inside the window must be ignored.
      ar = 5'd20;
      clk_en = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (i == 5) keyon = 1'b1;
         if (i == 12) keyon = 1'b0;
         tick(1);
      end
      check("gate_pure", eg_pure, 10'h3FF);
      check("gate_state", eg_state, 3);
      clk_en = 1'b1;
      tick(1);
      check("gate_after_state", eg_state, 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
